// File: rtl/watch_set_ctrl.sv
// Edit-mode control for watch_dp: digit select plus inc/dec/clear pulses.
// Define AUTO_REPEAT_EN to enable inc/dec auto-repeat while a button is held.
module watch_set_ctrl #(
   parameter int TIMEOUT_CYCLES = 1_000_000_000,
   parameter int HOLD_CYCLES    = 50_000_000,
   parameter int REPEAT_CYCLES  = 10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_clear,
   input  logic       btn_digit_move,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic [7:0] pc_data,
   input  logic       pc_valid,
   output logic [1:0] digit_mode,
   output logic       inc,
   output logic       dec,
   output logic       clear
);

   localparam logic [1:0] RUN = 2'b00;

   localparam logic [2:0] CMD_NONE = 3'd0;
   localparam logic [2:0] CMD_CLR  = 3'd1;
   localparam logic [2:0] CMD_MOV  = 3'd2;
   localparam logic [2:0] CMD_INC  = 3'd3;
   localparam logic [2:0] CMD_DEC  = 3'd4;

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic          clr_q, mov_q, inc_q, dec_q;
   logic          clr_ev, mov_ev, inc_ev, dec_ev;
   logic          rep_inc, rep_dec;
   logic          pend_v, pend_v_n;
   logic [2:0]    pend_cmd, pend_cmd_n;
   logic [2:0]    btn_cmd, pc_cmd, exec_cmd;
   logic [1:0]    mode_n;
   logic          inc_n, dec_n, clear_n;
   logic [TW-1:0] idle_cnt, idle_n;

   assign clr_ev = btn_clear & ~clr_q;
   assign mov_ev = btn_digit_move & ~mov_q;
   assign inc_ev = btn_inc & ~inc_q;
   assign dec_ev = btn_dec & ~dec_q;

   always_comb begin
      pc_cmd = CMD_NONE;
      if (pc_valid) begin
         case (pc_data)
            8'h43, 8'h63: pc_cmd = CMD_CLR;
            8'h4d, 8'h6d: pc_cmd = CMD_MOV;
            8'h55, 8'h75: pc_cmd = CMD_INC;
            8'h44, 8'h64: pc_cmd = CMD_DEC;
            default:      pc_cmd = CMD_NONE;
         endcase
      end
   end

   always_comb begin
      btn_cmd = CMD_NONE;
      if (clr_ev)                  btn_cmd = CMD_CLR;
      else if (mov_ev)             btn_cmd = CMD_MOV;
      else if (inc_ev || rep_inc)  btn_cmd = CMD_INC;
      else if (dec_ev || rep_dec)  btn_cmd = CMD_DEC;
   end

   // Buttons own the cycle; a PC command waits in the slot (last one wins).
   always_comb begin
      exec_cmd   = CMD_NONE;
      pend_v_n   = pend_v;
      pend_cmd_n = pend_cmd;
      if (btn_cmd != CMD_NONE) begin
         exec_cmd = btn_cmd;
         if (pc_cmd != CMD_NONE) begin
            pend_v_n   = 1'b1;
            pend_cmd_n = pc_cmd;
         end
      end else if (pc_cmd != CMD_NONE) begin
         exec_cmd = pc_cmd;
         pend_v_n = 1'b0;
      end else if (pend_v) begin
         exec_cmd = pend_cmd;
         pend_v_n = 1'b0;
      end
   end

   always_comb begin
      mode_n  = digit_mode;
      inc_n   = 1'b0;
      dec_n   = 1'b0;
      clear_n = 1'b0;
      idle_n  = '0;
      case (exec_cmd)
         CMD_CLR: begin
            clear_n = 1'b1;
            mode_n  = RUN;
         end
         CMD_MOV: mode_n = digit_mode + 2'd1;
         CMD_INC: inc_n  = (digit_mode != RUN);
         CMD_DEC: dec_n  = (digit_mode != RUN);
         default: begin
            if (digit_mode != RUN) begin
               if (idle_cnt == T_LAST) mode_n = RUN;
               else idle_n = idle_cnt + TW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_q      <= 1'b0;
         mov_q      <= 1'b0;
         inc_q      <= 1'b0;
         dec_q      <= 1'b0;
         pend_v     <= 1'b0;
         pend_cmd   <= CMD_NONE;
         idle_cnt   <= '0;
         digit_mode <= RUN;
         inc        <= 1'b0;
         dec        <= 1'b0;
         clear      <= 1'b0;
      end else begin
         clr_q      <= btn_clear;
         mov_q      <= btn_digit_move;
         inc_q      <= btn_inc;
         dec_q      <= btn_dec;
         pend_v     <= pend_v_n;
         pend_cmd   <= pend_cmd_n;
         idle_cnt   <= idle_n;
         digit_mode <= mode_n;
         inc        <= inc_n;
         dec        <= dec_n;
         clear      <= clear_n;
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HW = $clog2(HMAX);
   localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYCLES - 1);

   logic          rep_arm, rep_on, rep_fire;
   logic          inc_hold, dec_hold;
   logic [HW-1:0] hold_cnt;

   always_comb begin
      inc_hold = btn_inc & inc_q & ~btn_dec;
      dec_hold = btn_dec & dec_q & ~btn_inc;
      rep_fire = rep_arm & (inc_hold | dec_hold) &
                 (hold_cnt == (rep_on ? R_LAST : H_LAST));
      rep_inc  = rep_fire & inc_hold;
      rep_dec  = rep_fire & dec_hold;
   end

   // Armed only by an edge taken in an edit mode; any mode change disarms.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_arm  <= 1'b0;
         rep_on   <= 1'b0;
         hold_cnt <= '0;
      end else if (digit_mode == RUN || mode_n != digit_mode) begin
         rep_arm  <= 1'b0;
         rep_on   <= 1'b0;
         hold_cnt <= '0;
      end else if ((inc_ev & ~btn_dec) | (dec_ev & ~btn_inc)) begin
         rep_arm  <= 1'b1;
         rep_on   <= 1'b0;
         hold_cnt <= '0;
      end else if (!(inc_hold | dec_hold)) begin
         rep_arm  <= 1'b0;
         rep_on   <= 1'b0;
         hold_cnt <= '0;
      end else if (rep_arm) begin
         if (rep_fire) begin
            rep_on   <= 1'b1;
            hold_cnt <= '0;
         end else begin
            hold_cnt <= hold_cnt + HW'(1);
         end
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};
   assign rep_inc = 1'b0;
   assign rep_dec = 1'b0;
`endif

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl (TIMEOUT=100, HOLD=20, REPEAT=5).
// Build with +define+AUTO_REPEAT_EN to check the auto-repeat expectations.
module tb_watch_set_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_clear, btn_digit_move, btn_inc, btn_dec;
   logic [7:0] pc_data;
   logic       pc_valid;
   logic [1:0] digit_mode;
   logic       inc, dec, clear;

   int checks   = 0;
   int failures = 0;

   logic [4:0] exp_q[$];
   string      nm_q[$];
   logic [4:0] m_exp;
   string      m_nm;

   localparam logic [2:0] P0 = 3'b000;
   localparam logic [2:0] PI = 3'b100;
   localparam logic [2:0] PD = 3'b010;
   localparam logic [2:0] PC = 3'b001;
   localparam logic [3:0] B0   = 4'b0000;
   localparam logic [3:0] BMOV = 4'b0100;
   localparam logic [3:0] BINC = 4'b0010;
   localparam logic [3:0] BDEC = 4'b0001;

   typedef struct {
      logic [3:0] b;
      logic       pv;
      logic [7:0] pd;
      logic [1:0] m;
      logic [2:0] p;
   } vec_t;

   localparam int NV = 22;
   vec_t tbl[NV];

   watch_set_ctrl #(
      .TIMEOUT_CYCLES(100),
      .HOLD_CYCLES(20),
      .REPEAT_CYCLES(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_clear(btn_clear),
      .btn_digit_move(btn_digit_move),
      .btn_inc(btn_inc),
      .btn_dec(btn_dec),
      .pc_data(pc_data),
      .pc_valid(pc_valid),
      .digit_mode(digit_mode),
      .inc(inc),
      .dec(dec),
      .clear(clear)
   );

   always #5 clk = ~clk;

   task automatic check_now(input logic [4:0] exv, input string nm);
      logic [4:0] got;
      got = {digit_mode, inc, dec, clear};
      checks++;
      if (got !== exv) begin
         failures++;
         $display("FAIL %s: got mode=%b inc/dec/clr=%b, expected mode=%b inc/dec/clr=%b",
                  nm, got[4:3], got[2:0], exv[4:3], exv[2:0]);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         m_exp = exp_q.pop_front();
         m_nm  = nm_q.pop_front();
         check_now(m_exp, m_nm);
      end
   end

   task automatic drive(input logic [3:0] b, input logic pv, input logic [7:0] pd,
                        input logic [1:0] m, input logic [2:0] p, input string nm);
      @(negedge clk);
      {btn_clear, btn_digit_move, btn_inc, btn_dec} = b;
      pc_valid = pv;
      pc_data  = pd;
      exp_q.push_back({m, p});
      nm_q.push_back(nm);
   endtask

   function automatic logic rep_hit(input int j);
`ifdef AUTO_REPEAT_EN
      return (j == 0) || (j >= 20 && ((j - 20) % 5) == 0);
`else
      return (j == 0);
`endif
   endfunction

   initial begin
      tbl[0]  = '{BMOV, 1'b0, 8'h00, 2'b01, P0};
      tbl[1]  = '{B0,   1'b0, 8'h00, 2'b01, P0};
      tbl[2]  = '{BMOV, 1'b0, 8'h00, 2'b10, P0};
      tbl[3]  = '{B0,   1'b0, 8'h00, 2'b10, P0};
      tbl[4]  = '{BMOV, 1'b0, 8'h00, 2'b11, P0};
      tbl[5]  = '{B0,   1'b0, 8'h00, 2'b11, P0};
      tbl[6]  = '{BMOV, 1'b0, 8'h00, 2'b00, P0};
      tbl[7]  = '{B0,   1'b0, 8'h00, 2'b00, P0};
      tbl[8]  = '{BMOV, 1'b0, 8'h00, 2'b01, P0};
      tbl[9]  = '{BMOV, 1'b0, 8'h00, 2'b01, P0};
      tbl[10] = '{B0,   1'b0, 8'h00, 2'b01, P0};
      tbl[11] = '{B0,   1'b1, 8'h6d, 2'b10, P0};
      tbl[12] = '{B0,   1'b1, 8'h78, 2'b10, P0};
      tbl[13] = '{B0,   1'b1, 8'h4d, 2'b11, P0};
      tbl[14] = '{B0,   1'b1, 8'h43, 2'b00, PC};
      tbl[15] = '{B0,   1'b0, 8'h00, 2'b00, P0};
      tbl[16] = '{B0,   1'b1, 8'h78, 2'b00, P0};
      tbl[17] = '{B0,   1'b1, 8'h75, 2'b00, P0};
      tbl[18] = '{B0,   1'b1, 8'h4d, 2'b01, P0};
      tbl[19] = '{B0,   1'b1, 8'h55, 2'b01, PI};
      tbl[20] = '{B0,   1'b1, 8'h44, 2'b01, PD};
      tbl[21] = '{B0,   1'b1, 8'h63, 2'b00, PC};

      rst = 1'b1;
      {btn_clear, btn_digit_move, btn_inc, btn_dec} = B0;
      pc_valid = 1'b0;
      pc_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1 check_now(5'b0, "reset");
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < NV; i++)
         drive(tbl[i].b, tbl[i].pv, tbl[i].pd, tbl[i].m, tbl[i].p,
               $sformatf("tbl%0d", i));

      // inc hold in MIN, then in RUN
      drive(BMOV, 1'b0, 8'h00, 2'b01, P0, "t2_mv1");
      drive(B0,   1'b0, 8'h00, 2'b01, P0, "t2_mv1r");
      drive(BMOV, 1'b0, 8'h00, 2'b10, P0, "t2_mv2");
      drive(B0,   1'b0, 8'h00, 2'b10, P0, "t2_mv2r");
      for (int j = 0; j < 50; j++)
         drive(BINC, 1'b0, 8'h00, 2'b10, rep_hit(j) ? PI : P0,
               $sformatf("t2_hold%0d", j));
      for (int j = 0; j < 6; j++)
         drive(B0, 1'b0, 8'h00, 2'b10, P0, $sformatf("t2_rel%0d", j));
      drive(BMOV, 1'b0, 8'h00, 2'b11, P0, "t2_mv3");
      drive(B0,   1'b0, 8'h00, 2'b11, P0, "t2_mv3r");
      drive(BMOV, 1'b0, 8'h00, 2'b00, P0, "t2_mv4");
      drive(B0,   1'b0, 8'h00, 2'b00, P0, "t2_mv4r");
      for (int j = 0; j < 50; j++)
         drive(BINC, 1'b0, 8'h00, 2'b00, P0, $sformatf("t2_run%0d", j));
      drive(B0, 1'b0, 8'h00, 2'b00, P0, "t2_runrel");

      // PC clear from HOUR, then junk byte
      drive(BMOV, 1'b0, 8'h00, 2'b01, P0, "t3_mv1");
      drive(B0,   1'b0, 8'h00, 2'b01, P0, "t3_mv1r");
      drive(BMOV, 1'b0, 8'h00, 2'b10, P0, "t3_mv2");
      drive(B0,   1'b0, 8'h00, 2'b10, P0, "t3_mv2r");
      drive(BMOV, 1'b0, 8'h00, 2'b11, P0, "t3_mv3");
      drive(B0,   1'b0, 8'h00, 2'b11, P0, "t3_mv3r");
      drive(B0,   1'b1, 8'h43, 2'b00, PC, "t3_pcC");
      drive(B0,   1'b0, 8'h00, 2'b00, P0, "t3_after");
      drive(B0,   1'b1, 8'h78, 2'b00, P0, "t3_pcx");

      // button vs PC collision, then clear beats inc
      drive(BMOV, 1'b0, 8'h00, 2'b01, P0, "t4_mv");
      drive(B0,   1'b0, 8'h00, 2'b01, P0, "t4_mvr");
      drive(BDEC, 1'b1, 8'h55, 2'b01, PD, "t4_dec_vs_pc");
      drive(BDEC, 1'b0, 8'h00, 2'b01, PI, "t4_pending");
      drive(B0,   1'b0, 8'h00, 2'b01, P0, "t4_idle");
      drive(4'b1010, 1'b0, 8'h00, 2'b00, PC, "t4_clr_inc");
      drive(B0,   1'b0, 8'h00, 2'b00, P0, "t4_clr_r");

      // edit timeout, plain and restarted by an inc at cycle 90
      drive(BMOV, 1'b0, 8'h00, 2'b01, P0, "t5_mv");
      for (int j = 1; j <= 100; j++)
         drive(B0, 1'b0, 8'h00, (j < 100) ? 2'b01 : 2'b00, P0,
               $sformatf("t5_idle%0d", j));
      drive(BMOV, 1'b0, 8'h00, 2'b01, P0, "t5b_mv");
      for (int j = 1; j <= 190; j++)
         drive((j == 90) ? BINC : B0, 1'b0, 8'h00,
               (j < 190) ? 2'b01 : 2'b00, (j == 90) ? PI : P0,
               $sformatf("t5b_idle%0d", j));

      // long inc hold in MIN, release, re-hold, reset mid-edit
      drive(BMOV, 1'b0, 8'h00, 2'b01, P0, "t6_mv1");
      drive(B0,   1'b0, 8'h00, 2'b01, P0, "t6_mv1r");
      drive(BMOV, 1'b0, 8'h00, 2'b10, P0, "t6_mv2");
      drive(B0,   1'b0, 8'h00, 2'b10, P0, "t6_mv2r");
      for (int j = 0; j <= 40; j++)
         drive(BINC, 1'b0, 8'h00, 2'b10, rep_hit(j) ? PI : P0,
               $sformatf("t6_hold%0d", j));
      for (int j = 0; j < 8; j++)
         drive(B0, 1'b0, 8'h00, 2'b10, P0, $sformatf("t6_rel%0d", j));
      for (int j = 0; j <= 10; j++)
         drive(BINC, 1'b0, 8'h00, 2'b10, rep_hit(j) ? PI : P0,
               $sformatf("t6_rehold%0d", j));
      drive(4'b0110, 1'b1, 8'h4d, 2'b11, P0, "t6_mv_pend");
      @(posedge clk);
      #2 rst = 1'b1;
      {btn_clear, btn_digit_move, btn_inc, btn_dec} = B0;
      pc_valid = 1'b0;
      #1 check_now(5'b0, "t6_rst_mid");
      @(negedge clk) rst = 1'b0;
      drive(B0, 1'b0, 8'h00, 2'b00, P0, "t6_pend_dropped");
      drive(B0, 1'b0, 8'h00, 2'b00, P0, "t6_post_rst");

      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
